// File: rtl/bram_sdp.sv
// Simple dual-port block RAM: one byte-enabled write port and one read port
// sharing a single clock, with an optional output pipeline register and a
// selectable write/read collision behaviour.
module bram_sdp #(
  parameter int                    DATA_WIDTH = 25,
  parameter int                    ADDR_WIDTH = 9,
  parameter int                    WE_WIDTH   = (DATA_WIDTH + 7) / 8,
  parameter int                    DO_REG     = 0,
  parameter string                 WRITE_MODE = "WRITE_FIRST",
  parameter logic [DATA_WIDTH-1:0] INIT_OUT   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] di,
  input  logic [ADDR_WIDTH-1:0] wraddr,
  input  logic [ADDR_WIDTH-1:0] rdaddr,
  input  logic [WE_WIDTH-1:0]   we,
  input  logic                  wren,
  input  logic                  rden,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int DEPTH       = 2 ** ADDR_WIDTH;
  // Any mode other than READ_FIRST behaves as WRITE_FIRST.
  localparam bit WRITE_FIRST = (WRITE_MODE != "READ_FIRST");

  // Contents start at zero and are never cleared by reset.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  logic [DATA_WIDTH-1:0] byte_mask;
  logic [DATA_WIDTH-1:0] wr_word;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rd_reg;
  logic                  collide;

  // Expand each byte-write enable over its lane; the top lane may be partial.
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_mask
    if (i / 8 < WE_WIDTH) begin : g_lane
      assign byte_mask[i] = we[i / 8];
    end else begin : g_no_lane
      assign byte_mask[i] = 1'b0;
    end
  end

  // Word as it will look after the write: enabled lanes from di, others kept.
  assign wr_word = (mem[wraddr] & ~byte_mask) | (di & byte_mask);

  // A collision is a write and a read to the same word on the same edge.
  assign collide = wren && (wraddr == rdaddr);

  // WRITE_FIRST forwards the merged word on a collision; READ_FIRST returns
  // the contents from before the write.
  assign rd_word = (WRITE_FIRST && collide) ? wr_word : mem[rdaddr];

  // Write port: merged word stored on enabled edges, nothing while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n) begin
      if (wren) begin
        mem[wraddr] <= wr_word;
      end
    end
  end

  // Read register: loads on rden, holds otherwise, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_reg <= INIT_OUT;
    end else if (rden) begin
      rd_reg <= rd_word;
    end
  end

  if (DO_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] out_reg;

    // Output pipeline stage follows the read register every edge, ungated.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_reg <= INIT_OUT;
      end else begin
        out_reg <= rd_reg;
      end
    end

    assign dout = out_reg;
  end else begin : g_no_out_reg
    assign dout = rd_reg;
  end

endmodule

// File: tb/tb_bram_sdp.sv
// Self-checking bench for bram_sdp: one instance with default parameters
// (1-cycle latency, WRITE_FIRST) and one with the output register enabled,
// READ_FIRST collisions and a non-zero reset value, both driven by the same
// stimulus and compared against a word-level memory model.
module tb_bram_sdp;

  localparam int              DW     = 25;
  localparam int              AW     = 9;
  localparam int              WW     = 4;
  localparam int              DEPTH  = 512;
  localparam logic [DW-1:0]   INIT_B = 25'h1555555;

  logic          clk;
  logic          rst_n;
  logic          wren;
  logic          rden;
  logic [WW-1:0] we;
  logic [AW-1:0] wraddr;
  logic [AW-1:0] rdaddr;
  logic [DW-1:0] di;
  logic [DW-1:0] dout_a;
  logic [DW-1:0] dout_b;

  int    tests_run    = 0;
  int    tests_failed = 0;
  string phase        = "reset";

  // Reference model: plain word array plus the value each dout should show.
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] rd_a;
  logic [DW-1:0] rd_b;
  logic [DW-1:0] exp_a;
  logic [DW-1:0] exp_b;

  bram_sdp u_dut_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .di     (di),
    .wraddr (wraddr),
    .rdaddr (rdaddr),
    .we     (we),
    .wren   (wren),
    .rden   (rden),
    .dout   (dout_a)
  );

  bram_sdp #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .WE_WIDTH   (WW),
    .DO_REG     (1),
    .WRITE_MODE ("READ_FIRST"),
    .INIT_OUT   (INIT_B)
  ) u_dut_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .di     (di),
    .wraddr (wraddr),
    .rdaddr (rdaddr),
    .we     (we),
    .wren   (wren),
    .rden   (rden),
    .dout   (dout_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if the values differ.
  task automatic checkOutput(input string tag, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Drive one cycle's worth of inputs away from the rising edge.
  task automatic applyStimulus(input logic w_en, input logic r_en,
                               input logic [WW-1:0] w_be,
                               input logic [AW-1:0] wa, input logic [AW-1:0] ra,
                               input logic [DW-1:0] d);
    @(negedge clk);
    wren   = w_en;
    rden   = r_en;
    we     = w_be;
    wraddr = wa;
    rdaddr = ra;
    di     = d;
  endtask

  // Model of one rising edge, written from the memory's observable rules.
  always @(posedge clk) begin : model_edge
    logic [DW-1:0] new_word;
    logic [DW-1:0] old_rd;
    if (rst_n === 1'b1) begin
      new_word = model_mem[wraddr];
      for (int b = 0; b < DW; b++) begin
        if (we[b / 8]) new_word[b] = di[b];
      end
      old_rd = model_mem[rdaddr];
      exp_b  = rd_b;
      if (rden) begin
        rd_b = old_rd;
        rd_a = (wren && wraddr == rdaddr) ? new_word : old_rd;
      end
      if (wren) model_mem[wraddr] = new_word;
      exp_a = rd_a;
    end
  end

  // Reset clears both read paths at once; memory is untouched.
  always @(negedge rst_n) begin
    rd_a  = '0;
    exp_a = '0;
    rd_b  = INIT_B;
    exp_b = INIT_B;
  end

  // Continuous comparison of both outputs on every falling edge.
  always @(negedge clk) begin
    checkOutput({phase, "_a"}, dout_a, exp_a);
    checkOutput({phase, "_b"}, dout_b, exp_b);
  end

  initial begin
    rst_n  = 1'b0;
    wren   = 1'b0;
    rden   = 1'b0;
    we     = '0;
    wraddr = '0;
    rdaddr = '0;
    di     = '0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    rd_a  = '0;
    exp_a = '0;
    rd_b  = INIT_B;
    exp_b = INIT_B;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Untouched memory reads as zero.
    phase = "zero_init";
    applyStimulus(1'b0, 1'b1, 4'h0, 9'd0, 9'd100, 25'h0);
    applyStimulus(1'b0, 1'b0, 4'h0, 9'd0, 9'd0, 25'h0);

    // Circular shift register: write a, read a+1, data delayed by DEPTH.
    phase = "shift";
    for (int n = 0; n < 600; n++) begin
      applyStimulus(1'b1, 1'b1, 4'hF, AW'(n % DEPTH), AW'((n + 1) % DEPTH), DW'(n));
      if (n >= DEPTH - 1) begin
        @(posedge clk);
        #1;
        checkOutput("shift_delay", dout_a, DW'(n - (DEPTH - 1)));
      end
    end

    // Basic write then read, 1-cycle and 2-cycle latency.
    phase = "basic";
    applyStimulus(1'b1, 1'b0, 4'hF, 9'd5, 9'd0, 25'h0ABCDEF);
    applyStimulus(1'b0, 1'b1, 4'h0, 9'd0, 9'd5, 25'h0);
    @(posedge clk);
    #1;
    checkOutput("basic_lat1", dout_a, 25'h0ABCDEF);
    applyStimulus(1'b0, 1'b0, 4'h0, 9'd0, 9'd0, 25'h0);
    @(posedge clk);
    #1;
    checkOutput("basic_lat2", dout_b, 25'h0ABCDEF);

    // Byte enables 0 and 2 clear lanes [7:0] and [23:16] of 0x1FFFFFF.
    phase = "byte_en";
    applyStimulus(1'b1, 1'b0, 4'hF, 9'd7, 9'd0, 25'h1FFFFFF);
    applyStimulus(1'b1, 1'b0, 4'b0101, 9'd7, 9'd0, 25'h0000000);
    applyStimulus(1'b0, 1'b1, 4'h0, 9'd0, 9'd7, 25'h0);
    @(posedge clk);
    #1;
    checkOutput("byte_en", dout_a, 25'h100FF00);

    // Write and read of the same address on one edge.
    phase = "collision";
    applyStimulus(1'b1, 1'b0, 4'hF, 9'd3, 9'd0, 25'h0000011);
    applyStimulus(1'b1, 1'b1, 4'hF, 9'd3, 9'd3, 25'h0000022);
    @(posedge clk);
    #1;
    checkOutput("coll_write_first", dout_a, 25'h0000022);
    applyStimulus(1'b0, 1'b0, 4'h0, 9'd0, 9'd0, 25'h0);
    @(posedge clk);
    #1;
    checkOutput("coll_read_first", dout_b, 25'h0000011);

    // With rden low the output holds while rdaddr wanders.
    phase = "rden_hold";
    applyStimulus(1'b0, 1'b1, 4'h0, 9'd0, 9'd5, 25'h0);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b0, 1'b0, 4'h0, 9'd0, AW'(i * 37), 25'h0);
      @(posedge clk);
      #1;
      checkOutput("rden_hold", dout_a, 25'h0ABCDEF);
    end
    applyStimulus(1'b0, 1'b1, 4'h0, 9'd0, 9'd7, 25'h0);

    // Mid-stream reset: immediate clear, suppressed accesses, memory kept.
    phase = "reset_mid";
    applyStimulus(1'b0, 1'b1, 4'h0, 9'd0, 9'd3, 25'h0);
    applyStimulus(1'b1, 1'b1, 4'hF, 9'd9, 9'd5, 25'h0000123);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_a", dout_a, 25'h0);
    checkOutput("async_rst_b", dout_b, INIT_B);
    applyStimulus(1'b1, 1'b1, 4'hF, 9'd5, 9'd5, 25'h1234567);
    applyStimulus(1'b1, 1'b1, 4'hF, 9'd5, 9'd7, 25'h0765432);
    applyStimulus(1'b0, 1'b0, 4'h0, 9'd0, 9'd0, 25'h0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 4'h0, 9'd0, 9'd5, 25'h0);
    @(posedge clk);
    #1;
    checkOutput("rst_keep_a", dout_a, 25'h0ABCDEF);
    applyStimulus(1'b0, 1'b0, 4'h0, 9'd0, 9'd0, 25'h0);
    @(posedge clk);
    #1;
    checkOutput("rst_keep_b", dout_b, 25'h0ABCDEF);

    // Random traffic on a small address window to provoke collisions.
    phase = "random";
    for (int i = 0; i < 400; i++) begin
      logic [AW-1:0] wa;
      logic [AW-1:0] ra;
      wa = AW'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 15));
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    WW'($urandom), wa, ra, DW'($urandom));
    end

    applyStimulus(1'b0, 1'b0, 4'h0, 9'd0, 9'd0, 25'h0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
